// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Pipeline hazard/stall controller for the 5-stage RV32I core. It produces
//   the decoder's NoOp input (ID/EX bubble), the PC and IF/ID write enables,
//   the IF/ID flush and the global freeze. It handles load-use hazards,
//   EX-resolved redirects (taken branch, JAL, JALR) and cache-miss stalls.
//   It also keeps saturating stall/flush performance counters.
//
// Parameters
//   FLUSH_CYCLES  cycles of IF/ID flush + NoOp per redirect (1..7)
//   CNT_W         width of the performance counters
//
// Ports
//   clk, rst_n       core clock, asynchronous active-low reset
//   IFID_opcode_i    opcode of the instruction in ID
//   IFID_rs1_i/rs2_i source register fields of the instruction in ID
//   IDEX_MemRead_i   instruction in EX is a load
//   IDEX_rd_i        destination register of the instruction in EX
//   redirect_i       EX resolved a taken branch/JAL/JALR (1-cycle pulse)
//   ICACHE_stall_i   I-cache miss in progress
//   DCACHE_stall_i   D-cache miss in progress
//   NoOp_o           zero control word into ID/EX
//   PCWrite_o        PC register update enable
//   IFIDWrite_o      IF/ID register update enable
//   IFFlush_o        clear IF/ID to NOP
//   freeze_o         hold all pipeline registers
//   stall_cnt_o      cycles with PCWrite_o=0 (saturating)
//   flush_cnt_o      redirects applied (saturating)
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       IFID_opcode_i,
  input  logic [4:0]       IFID_rs1_i,
  input  logic [4:0]       IFID_rs2_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             redirect_i,
  input  logic             ICACHE_stall_i,
  input  logic             DCACHE_stall_i,
  output logic             NoOp_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFFlush_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic             MULTI_FLUSH  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       flush_left_r, flush_left_s;
  logic             pending_r, pending_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  logic uses_rs1_s, uses_rs2_s, load_use_s, mem_stall_s;
  logic noop_s, pcwrite_s, ifidwrite_s, ifflush_s, freeze_s, flush_inc_s;

  // Source-operand decode and load-use hazard detection for the ID instruction
  always_comb begin
    uses_rs1_s  = !((IFID_opcode_i == OPC_JAL) || (IFID_opcode_i == OPC_LUI) ||
                    (IFID_opcode_i == OPC_AUIPC));
    uses_rs2_s  = (IFID_opcode_i == OPC_OP) || (IFID_opcode_i == OPC_STORE) ||
                  (IFID_opcode_i == OPC_BRANCH);
    load_use_s  = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                  ((uses_rs1_s && (IDEX_rd_i == IFID_rs1_i)) ||
                   (uses_rs2_s && (IDEX_rd_i == IFID_rs2_i)));
    mem_stall_s = ICACHE_stall_i || DCACHE_stall_i;
  end

  // Prioritised next-state and control outputs (combinational, same cycle)
  always_comb begin
    state_s      = state_r;
    flush_left_s = flush_left_r;
    pending_s    = pending_r;
    flush_inc_s  = 1'b0;
    noop_s       = 1'b0;
    pcwrite_s    = 1'b1;
    ifidwrite_s  = 1'b1;
    ifflush_s    = 1'b0;
    freeze_s     = 1'b0;

    if (!rst_n) begin
      // Hold the pipeline quiet while reset is asserted.
      noop_s      = 1'b1;
      pcwrite_s   = 1'b0;
      ifidwrite_s = 1'b0;
    end else if (mem_stall_s) begin
      // A redirect seen during a miss is remembered and applied afterwards.
      freeze_s    = 1'b1;
      pcwrite_s   = 1'b0;
      ifidwrite_s = 1'b0;
      pending_s   = pending_r || redirect_i;
    end else if (redirect_i || pending_r) begin
      // Redirect wins over load-use: the dependent instruction is squashed.
      ifflush_s   = 1'b1;
      noop_s      = 1'b1;
      pending_s   = 1'b0;
      flush_inc_s = 1'b1;
      if (MULTI_FLUSH) begin
        state_s      = ST_FLUSH;
        flush_left_s = FLUSH_RELOAD;
      end else begin
        state_s      = ST_RUN;
        flush_left_s = 3'd0;
      end
    end else if (state_r == ST_FLUSH) begin
      ifflush_s = 1'b1;
      noop_s    = 1'b1;
      if (flush_left_r <= 3'd1) begin
        state_s      = ST_RUN;
        flush_left_s = 3'd0;
      end else begin
        flush_left_s = flush_left_r - 3'd1;
      end
    end else if (load_use_s) begin
      // One bubble is enough: it clears IDEX_MemRead on the next cycle.
      noop_s      = 1'b1;
      pcwrite_s   = 1'b0;
      ifidwrite_s = 1'b0;
    end else begin
      noop_s = 1'b0;
    end
  end

  // State, pending redirect and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      flush_left_r <= 3'd0;
      pending_r    <= 1'b0;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      flush_left_r <= flush_left_s;
      pending_r    <= pending_s;
      if (!pcwrite_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign NoOp_o      = noop_s;
  assign PCWrite_o   = pcwrite_s;
  assign IFIDWrite_o = ifidwrite_s;
  assign IFFlush_o   = ifflush_s;
  assign freeze_o    = freeze_s;
  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//   Directed bench for hazard_stall_unit with FLUSH_CYCLES=2, CNT_W=4.
//   Control outputs are checked as a packed vector
//   {NoOp, PCWrite, IFIDWrite, IFFlush, freeze}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // {NoOp, PCWrite, IFIDWrite, IFFlush, freeze}
  localparam logic [4:0] V_RUN    = 5'b01100;
  localparam logic [4:0] V_BUBBLE = 5'b10000;
  localparam logic [4:0] V_FLUSH  = 5'b11110;
  localparam logic [4:0] V_FREEZE = 5'b00001;
  localparam logic [4:0] V_RESET  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] IFID_opcode_i = 7'd0;
  logic [4:0] IFID_rs1_i = 5'd0;
  logic [4:0] IFID_rs2_i = 5'd0;
  logic       IDEX_MemRead_i = 1'b0;
  logic [4:0] IDEX_rd_i = 5'd0;
  logic       redirect_i = 1'b0;
  logic       ICACHE_stall_i = 1'b0;
  logic       DCACHE_stall_i = 1'b0;
  logic       NoOp_o, PCWrite_o, IFIDWrite_o, IFFlush_o, freeze_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  int n_cmp = 0;
  int n_mis = 0;

  hazard_stall_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_opcode_i(IFID_opcode_i), .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
    .redirect_i(redirect_i), .ICACHE_stall_i(ICACHE_stall_i), .DCACHE_stall_i(DCACHE_stall_i),
    .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
    .IFFlush_o(IFFlush_o), .freeze_o(freeze_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk_out(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {NoOp_o, PCWrite_o, IFIDWrite_o, IFFlush_o, freeze_o};
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic step(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic mr, input logic [4:0] rd, input logic rdr,
                      input logic ic, input logic dc);
    @(negedge clk);
    IFID_opcode_i  = op;
    IFID_rs1_i     = rs1;
    IFID_rs2_i     = rs2;
    IDEX_MemRead_i = mr;
    IDEX_rd_i      = rd;
    redirect_i     = rdr;
    ICACHE_stall_i = ic;
    DCACHE_stall_i = dc;
    #1;
  endtask

  task automatic idle();
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    IDEX_MemRead_i = 1'b0;
    redirect_i     = 1'b0;
    ICACHE_stall_i = 1'b0;
    DCACHE_stall_i = 1'b0;
    #1;
    chk_out("reset_outputs", V_RESET);
    chk_cnt("reset_stall_cnt", stall_cnt_o, 4'h0);
    chk_cnt("reset_flush_cnt", flush_cnt_o, 4'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // T1: load-use on rs1 and rs2, and a non-hazard on an unused rs2 field
    idle();                                                          chk_out("run_idle", V_RUN);
    step(OP_R, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);           chk_out("lu_rs1", V_BUBBLE);
    idle();                                                          chk_out("lu_rs1_after", V_RUN);
    chk_cnt("lu_rs1_stall_cnt", stall_cnt_o, 4'h1);
    step(OP_STORE, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);       chk_out("lu_rs2_store", V_BUBBLE);
    step(OP_IMM, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);         chk_out("imm_rs2_field", V_RUN);
    chk_cnt("lu_rs2_stall_cnt", stall_cnt_o, 4'h2);

    // T2: x0 destination and instructions without an rs1 source
    step(OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);           chk_out("lw_x0", V_RUN);
    step(OP_JAL, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);         chk_out("jal_rs1", V_RUN);
    step(OP_LUI, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);         chk_out("lui_rs1", V_RUN);
    step(OP_AUIPC, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);       chk_out("auipc_rs1", V_RUN);
    chk_cnt("no_stall_cnt", stall_cnt_o, 4'h2);

    // T3: redirect flushes for two cycles; a redirect inside FLUSH restarts it
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);         chk_out("redir_c1", V_FLUSH);
    idle();                                                          chk_out("redir_c2", V_FLUSH);
    chk_cnt("redir_flush_cnt", flush_cnt_o, 4'h1);
    idle();                                                          chk_out("redir_done", V_RUN);
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);         chk_out("restart_c1", V_FLUSH);
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);         chk_out("restart_c2", V_FLUSH);
    chk_cnt("restart_flush_cnt_a", flush_cnt_o, 4'h2);
    idle();                                                          chk_out("restart_c3", V_FLUSH);
    idle();                                                          chk_out("restart_done", V_RUN);
    chk_cnt("restart_flush_cnt_b", flush_cnt_o, 4'h3);

    // T4: redirect during a 3-cycle D-cache miss is applied after the miss
    do_reset();
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);         chk_out("miss_c1", V_FREEZE);
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);         chk_out("miss_c2", V_FREEZE);
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);         chk_out("miss_c3", V_FREEZE);
    idle();                                                          chk_out("pending_applied", V_FLUSH);
    chk_cnt("miss_stall_cnt", stall_cnt_o, 4'h3);
    chk_cnt("miss_flush_cnt_pre", flush_cnt_o, 4'h0);
    idle();                                                          chk_out("pending_flush_c2", V_FLUSH);
    chk_cnt("miss_flush_cnt", flush_cnt_o, 4'h1);
    idle();                                                          chk_out("pending_done", V_RUN);
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);         chk_out("icache_miss", V_FREEZE);

    // T5: redirect and load-use together -> flush only
    step(OP_R, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);           chk_out("redir_over_lu", V_FLUSH);
    chk_cnt("redir_lu_stall_pre", stall_cnt_o, 4'h4);
    idle();                                                          chk_out("redir_lu_c2", V_FLUSH);
    idle();                                                          chk_out("redir_lu_done", V_RUN);
    chk_cnt("redir_lu_stall_cnt", stall_cnt_o, 4'h4);
    chk_cnt("redir_lu_flush_cnt", flush_cnt_o, 4'h2);

    // T6: reset mid-FLUSH and with a pending redirect: nothing is replayed
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);         chk_out("pre_rst_flush", V_FLUSH);
    do_reset();
    idle();                                                          chk_out("post_rst_run", V_RUN);
    step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);         chk_out("pre_rst_pending", V_FREEZE);
    do_reset();
    idle();                                                          chk_out("pending_dropped", V_RUN);

    // Saturation: 20 stall cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      if (i == 14) chk_cnt("sat_cnt_14", stall_cnt_o, 4'hE);
      if (i == 15) chk_cnt("sat_cnt_15", stall_cnt_o, 4'hF);
    end
    chk_out("sat_freeze", V_FREEZE);
    idle();                                                          chk_out("sat_done", V_RUN);
    chk_cnt("sat_cnt_hold", stall_cnt_o, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
